// File: rtl/sub_64bit_pipe.sv
// Four-stage pipelined 64-bit subtractor: diff = a - b - b_in, computed as a + ~b + ~b_in.
// Each stage resolves one 16-bit slice; a global valid/ready stall holds every stage at once.
module sub_64bit_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        b_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] diff,
  output logic        b_out,
  output logic        ovf
);

  logic        adv;
  logic [3:0]  v_q, v_d;

  logic [15:0] s0_diff_q, s0_diff_d;
  logic        s0_c_q, s0_c_d;
  logic [47:0] s0_a_q, s0_a_d, s0_nb_q, s0_nb_d;
  logic        s0_sa_q, s0_sa_d, s0_sb_q, s0_sb_d;

  logic [31:0] s1_diff_q, s1_diff_d;
  logic        s1_c_q, s1_c_d;
  logic [31:0] s1_a_q, s1_a_d, s1_nb_q, s1_nb_d;
  logic        s1_sa_q, s1_sa_d, s1_sb_q, s1_sb_d;

  logic [47:0] s2_diff_q, s2_diff_d;
  logic        s2_c_q, s2_c_d;
  logic [15:0] s2_a_q, s2_a_d, s2_nb_q, s2_nb_d;
  logic        s2_sa_q, s2_sa_d, s2_sb_q, s2_sb_d;

  logic [63:0] diff_q, diff_d;
  logic        b_out_q, b_out_d;
  logic        ovf_q, ovf_d;

  logic [16:0] sum0, sum1, sum2, sum3;

  // The subtrahend is inverted once on entry so later slices are plain adds.
  always_comb begin
    adv      = ~v_q[3] | out_ready;
    in_ready = adv & ~rst;

    sum0 = {1'b0, a[15:0]}       + {1'b0, ~b[15:0]}    + {16'b0, ~b_in};
    sum1 = {1'b0, s0_a_q[15:0]}  + {1'b0, s0_nb_q[15:0]} + {16'b0, s0_c_q};
    sum2 = {1'b0, s1_a_q[15:0]}  + {1'b0, s1_nb_q[15:0]} + {16'b0, s1_c_q};
    sum3 = {1'b0, s2_a_q}        + {1'b0, s2_nb_q}       + {16'b0, s2_c_q};

    v_d       = v_q;
    s0_diff_d = s0_diff_q;  s0_c_d = s0_c_q;  s0_a_d = s0_a_q;  s0_nb_d = s0_nb_q;
    s0_sa_d   = s0_sa_q;    s0_sb_d = s0_sb_q;
    s1_diff_d = s1_diff_q;  s1_c_d = s1_c_q;  s1_a_d = s1_a_q;  s1_nb_d = s1_nb_q;
    s1_sa_d   = s1_sa_q;    s1_sb_d = s1_sb_q;
    s2_diff_d = s2_diff_q;  s2_c_d = s2_c_q;  s2_a_d = s2_a_q;  s2_nb_d = s2_nb_q;
    s2_sa_d   = s2_sa_q;    s2_sb_d = s2_sb_q;
    diff_d    = diff_q;     b_out_d = b_out_q; ovf_d = ovf_q;

    if (adv) begin
      v_d = {v_q[2:0], in_valid & in_ready};

      s0_diff_d = sum0[15:0];
      s0_c_d    = sum0[16];
      s0_a_d    = a[63:16];
      s0_nb_d   = ~b[63:16];
      s0_sa_d   = a[63];
      s0_sb_d   = b[63];

      s1_diff_d = {sum1[15:0], s0_diff_q};
      s1_c_d    = sum1[16];
      s1_a_d    = s0_a_q[47:16];
      s1_nb_d   = s0_nb_q[47:16];
      s1_sa_d   = s0_sa_q;
      s1_sb_d   = s0_sb_q;

      s2_diff_d = {sum2[15:0], s1_diff_q};
      s2_c_d    = sum2[16];
      s2_a_d    = s1_a_q[31:16];
      s2_nb_d   = s1_nb_q[31:16];
      s2_sa_d   = s1_sa_q;
      s2_sb_d   = s1_sb_q;

      diff_d  = {sum3[15:0], s2_diff_q};
      b_out_d = ~sum3[16];
      ovf_d   = (s2_sa_q ^ s2_sb_q) & (sum3[15] ^ s2_sa_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q       <= '0;
      s0_diff_q <= '0;  s0_c_q <= 1'b0;  s0_a_q <= '0;  s0_nb_q <= '0;
      s0_sa_q   <= 1'b0; s0_sb_q <= 1'b0;
      s1_diff_q <= '0;  s1_c_q <= 1'b0;  s1_a_q <= '0;  s1_nb_q <= '0;
      s1_sa_q   <= 1'b0; s1_sb_q <= 1'b0;
      s2_diff_q <= '0;  s2_c_q <= 1'b0;  s2_a_q <= '0;  s2_nb_q <= '0;
      s2_sa_q   <= 1'b0; s2_sb_q <= 1'b0;
      diff_q    <= '0;  b_out_q <= 1'b0; ovf_q <= 1'b0;
    end else begin
      v_q       <= v_d;
      s0_diff_q <= s0_diff_d;  s0_c_q <= s0_c_d;  s0_a_q <= s0_a_d;  s0_nb_q <= s0_nb_d;
      s0_sa_q   <= s0_sa_d;    s0_sb_q <= s0_sb_d;
      s1_diff_q <= s1_diff_d;  s1_c_q <= s1_c_d;  s1_a_q <= s1_a_d;  s1_nb_q <= s1_nb_d;
      s1_sa_q   <= s1_sa_d;    s1_sb_q <= s1_sb_d;
      s2_diff_q <= s2_diff_d;  s2_c_q <= s2_c_d;  s2_a_q <= s2_a_d;  s2_nb_q <= s2_nb_d;
      s2_sa_q   <= s2_sa_d;    s2_sb_q <= s2_sb_d;
      diff_q    <= diff_d;     b_out_q <= b_out_d; ovf_q <= ovf_d;
    end
  end

  assign out_valid = v_q[3];
  assign diff      = diff_q;
  assign b_out     = b_out_q;
  assign ovf       = ovf_q;

endmodule
